// File: rtl/pwm_pkg.sv
// Purpose: shared widths, counter limits and sample conversion for the PWM DAC output stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: none; pacing is done by the request strobe in pwm_dac_out.
package pwm_pkg;

    localparam int N_FRAC_DEF = 7;

    // Sample width: one sign bit plus the fractional bits.
    function automatic int pwm_width(input int n_frac);
        return n_frac + 1;
    endfunction

    // Last count of a PWM period for a given sample width.
    function automatic int pwm_cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int W_DEF       = pwm_width(N_FRAC_DEF);
    localparam int PWM_CNT_MAX = pwm_cnt_max(W_DEF);

    // Two's complement to offset binary: flipping the sign bit maps
    // the most negative sample to 0 and zero to mid-scale.
    function automatic logic [31:0] to_offset_bin(input logic [31:0] sample, input int w);
        return sample ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Purpose: prescaler producing one count-enable tick every PRESCALE cycles while enabled.
// Latency: tick is combinational from the registered prescaler count.
// Backpressure: none; enable low clears the count so the next run starts aligned.
module pwm_tick_gen #(
    parameter  int PRESCALE = 1,
    localparam int PW       = $clog2(PRESCALE) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_cnt;

    assign tick = enable && (presc_cnt == LAST);

    // Count 0..PRESCALE-1 while enabled, wrapping on tick; held at 0 when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (!enable || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_dac_out.sv
// Purpose: double-buffered PWM DAC; signed samples become duty cycles, one sample request per period.
// Latency: a sample captured in period k drives the pin for all of period k+1; pin lags counter by 1 cycle.
// Backpressure: upstream is paced by sample_req_o; optional PWM_STATUS_EN adds sticky underrun/overrun flags.
module pwm_dac_out
    import pwm_pkg::*;
#(
    parameter  int N_FRAC   = 7,
    parameter  int PRESCALE = 1,
    localparam int W        = pwm_width(N_FRAC)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic [W-1:0] data_i,
    input  logic         data_valid_strobe_i,
    output logic         sample_req_o,
    output logic         pwm_o,
    output logic         underrun_o,
    output logic         overrun_o
);

    localparam logic [W-1:0] CNT_MAX = W'(pwm_cnt_max(W));

    logic         tick;
    logic         wrap;
    logic         transfer;
    logic         enable_q;
    logic [W-1:0] pwm_cnt;
    logic [W-1:0] conv;
    logic [W-1:0] shadow;
    logic         shadow_full;
    logic [W-1:0] duty_active;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk_i),
        .rst    (rst_i),
        .enable (enable_i),
        .tick   (tick)
    );

    assign conv     = W'(to_offset_bin(32'(data_i), W));
    assign wrap     = tick && (pwm_cnt == CNT_MAX);
    assign transfer = wrap && shadow_full;

    // Period counter advances on each tick and restarts from 0 whenever disabled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt <= '0;
        end else if (!enable_i) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Registered pin compare and request pulse (period wrap or first enabled cycle).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q     <= 1'b0;
            sample_req_o <= 1'b0;
            pwm_o        <= 1'b0;
        end else begin
            enable_q     <= enable_i;
            sample_req_o <= wrap || (enable_i && !enable_q);
            pwm_o        <= enable_i && (pwm_cnt < duty_active);
        end
    end

    // Double buffer: old shadow moves to the active duty on wrap before a coincident
    // new sample refills the shadow, so a strobe on the wrap cycle never bypasses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
            duty_active <= '0;
        end else begin
            if (transfer) begin
                duty_active <= shadow;
            end
            if (data_valid_strobe_i) begin
                shadow      <= conv;
                shadow_full <= 1'b1;
            end else if (transfer) begin
                shadow_full <= 1'b0;
            end
        end
    end

`ifdef PWM_STATUS_EN
    logic got_sample;
    logic underrun_q;
    logic overrun_q;

    // Sticky flags: underrun only counts once upstream has delivered at least one sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            got_sample <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (data_valid_strobe_i) begin
                got_sample <= 1'b1;
            end
            if (wrap && !shadow_full && got_sample) begin
                underrun_q <= 1'b1;
            end
            if (data_valid_strobe_i && shadow_full && !transfer) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign underrun_o = underrun_q;
    assign overrun_o  = overrun_q;
`else
    assign underrun_o = 1'b0;
    assign overrun_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_dac_out.sv
// Purpose: randomized and directed bench for pwm_dac_out against a period-level reference model.
// Latency: model predicts registered outputs one cycle after the inputs they depend on.
// Backpressure: bench answers sample requests with random delays, sometimes withholding or doubling samples.
module tb_pwm_dac_out;

    localparam int PER = 256;
`ifdef PWM_STATUS_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [7:0] data_i;
    logic       data_valid_strobe_i;
    logic       sample_req_o;
    logic       pwm_o;
    logic       underrun_o;
    logic       overrun_o;

    always #5 clk_i = ~clk_i;

    pwm_dac_out #(
        .N_FRAC   (7),
        .PRESCALE (1)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .enable_i            (enable_i),
        .data_i              (data_i),
        .data_valid_strobe_i (data_valid_strobe_i),
        .sample_req_o        (sample_req_o),
        .pwm_o               (pwm_o),
        .underrun_o          (underrun_o),
        .overrun_o           (overrun_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: counts since enable, active duty, pending sample (-1 = none).
    int t, m_duty, m_pend, m_got, m_under, m_over, prev_en;
    int exp_pwm, exp_req;
    int hi_cnt, duty_used, last_hi, periods_done, period_clean, req_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_duty = 0; m_pend = -1; m_got = 0; m_under = 0; m_over = 0; prev_en = 0;
        exp_pwm = 0; exp_req = 0; hi_cnt = 0; duty_used = 0; last_hi = -1;
        period_clean = 0; req_seen = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input int en, input int vld, input logic [7:0] d);
        int cnt;
        int boundary;
        int transfer;
        enable_i            = (en != 0);
        data_valid_strobe_i = (vld != 0);
        data_i              = d;
        @(posedge clk_i);
        cnt = -1;
        boundary = 0;
        if (en != 0) begin
            cnt      = t % PER;
            boundary = (cnt == PER - 1) ? 1 : 0;
            exp_pwm  = (cnt < m_duty) ? 1 : 0;
            exp_req  = (boundary != 0 || prev_en == 0) ? 1 : 0;
            if (cnt == 0) begin
                period_clean = 1;
                hi_cnt       = 0;
                duty_used    = m_duty;
            end
            t++;
        end else begin
            t = 0; exp_pwm = 0; exp_req = 0; period_clean = 0;
        end
        transfer = (boundary != 0 && m_pend >= 0) ? 1 : 0;
        if (boundary != 0 && m_pend < 0 && m_got != 0) m_under = 1;
        if (vld != 0 && m_pend >= 0 && transfer == 0) m_over = 1;
        if (transfer != 0) begin
            m_duty = m_pend;
            m_pend = -1;
        end
        if (vld != 0) begin
            m_pend = int'(d ^ 8'h80);
            m_got  = 1;
        end
        prev_en = en;
        @(negedge clk_i);
        check_eq("pwm", 32'(pwm_o), exp_pwm);
        check_eq("req", 32'(sample_req_o), exp_req);
        check_eq("underrun", 32'(underrun_o), (STAT != 0) ? m_under : 0);
        check_eq("overrun", 32'(overrun_o), (STAT != 0) ? m_over : 0);
        if (sample_req_o) req_seen++;
        if (cnt >= 0 && period_clean != 0) begin
            hi_cnt += int'(pwm_o);
            if (cnt == PER - 1) begin
                check_eq("period_hi", 32'(hi_cnt), duty_used);
                last_hi = hi_cnt;
                periods_done++;
            end
        end
        data_valid_strobe_i = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 8'h00);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 600; i++) begin
            if (sample_req_o) return;
            step(1, 0, 8'h00);
        end
        check_eq("req_timeout", 32'(sample_req_o), 1);
    endtask

    task automatic run_until(input int target);
        for (int i = 0; i < 2000 && periods_done < target; i++) step(1, 0, 8'h00);
        if (periods_done < target) check_eq("period_timeout", 32'(periods_done), target);
    endtask

    task automatic feed(input logic [7:0] d);
        wait_req();
        run(int'($urandom_range(1, 150)));
        step(1, 1, d);
    endtask

    // Feed a value in two consecutive periods; the second of those periods shows its duty.
    task automatic apply_and_check(input logic [7:0] d, input int expect_hi, input string tag);
        int start;
        wait_req();
        start = periods_done;
        run(int'($urandom_range(1, 150)));
        step(1, 1, d);
        feed(d);
        run_until(start + 2);
        check_eq(tag, 32'(last_hi), expect_hi);
    endtask

    initial begin
        int start;
        int resp_cd;
        int dis_cd;
        int en;
        int vld;
        periods_done = 0;
        model_reset();
        rst_i = 1'b0; enable_i = 1'b0; data_valid_strobe_i = 1'b0; data_i = 8'h00;

        // Reset asserted between clock edges.
        #3 rst_i = 1'b1;
        #1;
        check_eq("rst_pwm", 32'(pwm_o), 0);
        check_eq("rst_req", 32'(sample_req_o), 0);
        check_eq("rst_under", 32'(underrun_o), 0);
        check_eq("rst_over", 32'(overrun_o), 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();

        // Startup: exactly one request in the first enabled cycles.
        run(20);
        check_eq("startup_req_count", 32'(req_seen), 1);

        // Mid-scale, minimum and maximum duty.
        apply_and_check(8'h00, 128, "duty_zero");
        apply_and_check(8'h00, 128, "duty_zero_again");
        apply_and_check(8'h80, 0, "duty_min");
        apply_and_check(8'h7F, 255, "duty_max");
        check_eq("underrun_clear", 32'(underrun_o), 0);

        // Withhold data across a wrap: duty held, underrun set.
        apply_and_check(8'h40, 192, "duty_192");
        start = periods_done;
        run_until(start + 2);
        check_eq("duty_held", 32'(last_hi), 192);
        check_eq("underrun_set", 32'(underrun_o), STAT);
        check_eq("overrun_clear", 32'(overrun_o), 0);

        // Two strobes in one period: last one wins, overrun set.
        wait_req();
        step(1, 1, 8'h10);
        run(5);
        step(1, 1, 8'h20);
        start = periods_done;
        run_until(start + 2);
        check_eq("double_strobe", 32'(last_hi), 160);
        check_eq("overrun_set", 32'(overrun_o), STAT);

        // Strobe on the wrap cycle: old shadow first, new one a period later.
        wait_req();
        step(1, 1, 8'h50);
        for (int i = 0; i < 600 && (t % PER) != PER - 1; i++) step(1, 0, 8'h00);
        step(1, 1, 8'h30);
        start = periods_done;
        run_until(start + 1);
        check_eq("coincident_old", 32'(last_hi), 208);
        run_until(start + 2);
        check_eq("coincident_new", 32'(last_hi), 176);

        // Drop enable mid-period for 10 cycles.
        run(100);
        for (int i = 0; i < 10; i++) step(0, 0, 8'h00);
        step(1, 0, 8'h00);
        check_eq("reenable_req", 32'(sample_req_o), 1);
        start = periods_done;
        run_until(start + 1);
        check_eq("reenable_duty", 32'(last_hi), 176);

        // Randomized traffic: random delays, withheld and extra strobes, enable drops.
        resp_cd = -1;
        dis_cd  = 0;
        for (int i = 0; i < 12000; i++) begin
            en = 1;
            if (dis_cd > 0) begin
                en = 0;
                dis_cd--;
            end else if ($urandom_range(0, 1999) == 0) begin
                dis_cd = int'($urandom_range(3, 20));
            end
            vld = (resp_cd == 0) ? 1 : 0;
            if (resp_cd >= 0) resp_cd--;
            if ($urandom_range(0, 399) == 0) vld = 1;
            step(en, vld, 8'($urandom));
            if (sample_req_o && $urandom_range(0, 7) != 0) resp_cd = int'($urandom_range(0, 250));
        end

        // Async reset while the pin is high.
        apply_and_check(8'h7F, 255, "pre_rst_duty");
        run(3);
        check_eq("pre_rst_pwm", 32'(pwm_o), 1);
        #2 rst_i = 1'b1;
        #1;
        check_eq("async_rst_pwm", 32'(pwm_o), 0);
        check_eq("async_rst_req", 32'(sample_req_o), 0);
        check_eq("async_rst_under", 32'(underrun_o), 0);
        check_eq("async_rst_over", 32'(overrun_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        run(10);
        check_eq("post_rst_req_count", 32'(req_seen), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
